rca_serial_addsub_64bit: RTL and testbench

Multi-cycle adder/subtractor sharing the 64-bit ripple-carry datapath format: `{carry_or_borrow, sum}` in a WIDTH+1 result. Each cycle it ripples CHUNK bits through a CHUNK-wide full-adder chain and registers the carry between chunks. Operands are accepted and results returned over valid/ready handshakes. It sits between operand producers and result consumers where a full-width combinational ripple does not meet timing.

---
 rtl/rca_serial_addsub_64bit.sv | 72 +++++++
 tb/tb_rca_serial_addsub_64bit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rca_serial_addsub_64bit.sv
// rca_serial_addsub_64bit: multi-cycle add/sub rippling CHUNK bits per cycle with a registered inter-chunk carry
module rca_serial_addsub_64bit #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, b_q, acc, acc_next;
    logic [CHUNK-1:0] s;
    logic [IW-1:0]    idx;
    logic             sub_q, carry, c_out, last;

    generate
        if (WIDTH % CHUNK != 0 || N < 1) begin : g_width_check
            $error("WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    // Operands shift right each cycle so the low CHUNK bits are always the live chunk
    always_comb begin
        {c_out, s} = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
        acc_next   = (acc >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));
        last       = idx == IW'(N - 1);
        state_next = state == IDLE ? (i_valid ? RUN : IDLE) :
                     state == RUN  ? (last ? DONE : RUN) :
                                     (i_ready ? IDLE : DONE);
    end

    assign o_ready = state == IDLE;
    assign o_valid = state == DONE;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            o_result <= '0;
            idx      <= '0;
            carry    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && i_valid) begin
                a_q   <= i_add_term1;
                b_q   <= i_sub ? ~i_add_term2 : i_add_term2;
                sub_q <= i_sub;
                carry <= i_sub;
                idx   <= '0;
            end else if (state == RUN) begin
                a_q   <= a_q >> CHUNK;
                b_q   <= b_q >> CHUNK;
                acc   <= acc_next;
                carry <= c_out;
                idx   <= idx + 1'b1;
                if (last)
                    o_result <= {c_out ^ sub_q, acc_next};
            end
        end
    end
endmodule

// File: tb/tb_rca_serial_addsub_64bit.sv
// tb_rca_serial_addsub_64bit: directed vectors with hand-computed results for rca_serial_addsub_64bit
module tb_rca_serial_addsub_64bit;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_sub, out_ready, in_ready, out_valid;
    logic [63:0] term1, term2;
    logic [64:0] result;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    rca_serial_addsub_64bit dut (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(out_ready),
        .i_add_term1(term1), .i_add_term2(term2), .i_sub(in_sub),
        .o_valid(out_valid), .i_ready(in_ready), .o_result(result)
    );

    task automatic check(input string tag, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge right after the accepting edge
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic s);
        int n = 0;
        in_valid = 1'b1;
        term1    = a;
        term2    = b;
        in_sub   = s;
        while (!out_ready && n < 50) begin
            cycle();
            n++;
        end
        check("accept_ready", 65'(out_ready), 65'd1);
        cycle();
        in_valid = 1'b0;
        term1    = 64'hDEAD_BEEF_DEAD_BEEF;
        term2    = 64'h1357_9BDF_1357_9BDF;
        in_sub   = ~s;
    endtask

    task automatic wait_result(input string tag, input logic [64:0] exp);
        int n = 0;
        while (!out_valid && n < 50) begin
            cycle();
            n++;
        end
        check({tag, "_latency"}, 65'(n), 65'd8);
        check(tag, result, exp);
    endtask

    task automatic finish_handshake(input string tag);
        in_ready = 1'b1;
        cycle();
        check({tag, "_valid_drop"}, 65'(out_valid), 65'd0);
        check({tag, "_ready_back"}, 65'(out_ready), 65'd1);
    endtask

    task automatic op(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic s, input logic [64:0] exp);
        send(a, b, s);
        wait_result(tag, exp);
        finish_handshake(tag);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_ready = 1'b1;
        in_sub   = 1'b0;
        term1    = '0;
        term2    = '0;
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_ready",  65'(out_ready), 65'd1);
        check("rst_valid",  65'(out_valid), 65'd0);
        check("rst_result", result, 65'd0);

        op("sub_5_3",   64'd5, 64'd3, 1'b1, {1'b0, 64'h2});
        op("sub_3_5",   64'd3, 64'd5, 1'b1, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
        op("add_ovf",   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, {1'b1, 64'h0});
        op("sub_cross", 64'h0000_0001_0000_0000, 64'd1, 1'b1, {1'b0, 64'h0000_0000_FFFF_FFFF});
        op("add_mix",   64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
        op("sub_zero",  64'd0, 64'd0, 1'b1, {1'b0, 64'h0});
        op("sub_eq",    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, {1'b0, 64'h0});

        in_ready = 1'b0;
        send(64'd100, 64'd58, 1'b1);
        wait_result("bp_first", {1'b0, 64'd42});
        in_valid = 1'b1;
        term1    = 64'd20;
        term2    = 64'd22;
        in_sub   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_valid",  65'(out_valid), 65'd1);
            check("bp_result", result, {1'b0, 64'd42});
            check("bp_ready",  65'(out_ready), 65'd0);
        end
        in_ready = 1'b1;
        cycle();
        check("bp_ready_back", 65'(out_ready), 65'd1);
        check("bp_valid_drop", 65'(out_valid), 65'd0);
        check("bp_result_hold", result, {1'b0, 64'd42});
        cycle();
        in_valid = 1'b0;
        check("bp_pending_taken", 65'(out_ready), 65'd0);
        wait_result("bp_second", {1'b0, 64'd42});
        finish_handshake("bp_second");

        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_valid",  65'(out_valid), 65'd0);
        check("mid_rst_result", result, 65'd0);
        check("mid_rst_ready",  65'(out_ready), 65'd1);
        op("after_rst", 64'd10, 64'd7, 1'b0, {1'b0, 64'h11});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
